alu_exec_unit: RTL and testbench

Parametrised multicycle ALU execute unit for the multicycle SOC datapath. It merges ALUop/Fun decoding with a registered result stage, and adds iterative shifts and an iterative unsigned multiply behind a start/done handshake. It sits between the register-file A/B latches and the ALUOut register. The controller FSM waits on `done` instead of assuming fixed single-cycle execution.

---
 rtl/alu_exec_unit.sv | 190 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Multicycle ALU execute unit: single-cycle ALU ops plus iterative shifts and an
// iterative unsigned multiply, all reporting completion through a one-cycle done pulse.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       Fun,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             zero,
    output logic             ovf,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
        OP_SLL, OP_SRL, OP_SRA, OP_MULTU, OP_ERR
    } op_t;

    state_t           state;
    op_t              shift_op;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_hi;

    op_t              op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_err;
    logic             iterative;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH:0]   mul_sum;

    assign shamt = B[SHW-1:0];
    assign sum   = A + B;
    assign diff  = A - B;
    assign busy  = (state != IDLE);

    always_comb begin
        op = OP_ERR;
        case (ALUop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b11: op = OP_OR;
            default: begin
                case (Fun)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b000000: op = OP_SLL;
                    6'b000010: op = OP_SRL;
                    6'b000011: op = OP_SRA;
                    6'b011001: op = OP_MULTU;
                    default:   op = OP_ERR;
                endcase
            end
        endcase
    end

    // Shifts by zero complete in one cycle and simply pass A through.
    always_comb begin
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        iterative = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:   alu_res = A & B;
            OP_OR:    alu_res = A | B;
            OP_XOR:   alu_res = A ^ B;
            OP_NOR:   alu_res = ~(A | B);
            OP_SLT:   alu_res = ($signed(A) < $signed(B)) ? WIDTH'(1) : '0;
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_res   = A;
                iterative = (shamt != '0);
            end
            OP_MULTU: iterative = 1'b1;
            default:  alu_err = 1'b1;
        endcase
    end

    always_comb begin
        case (shift_op)
            OP_SLL:  shift_next = {res[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_next = {1'b0, res[WIDTH-1:1]};
            default: shift_next = {res[WIDTH-1], res[WIDTH-1:1]};
        endcase
    end

    // {acc_hi, mplier} is the running product; the multiplier drains out of the low half.
    assign mul_sum = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift_op <= OP_SLL;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc_hi   <= '0;
            res      <= '0;
            res_hi   <= '0;
            zero     <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!iterative) begin
                            res    <= alu_res;
                            res_hi <= '0;
                            zero   <= (alu_res == '0);
                            ovf    <= alu_ovf;
                            err    <= alu_err;
                            done   <= 1'b1;
                        end else if (op == OP_MULTU) begin
                            mcand  <= A;
                            mplier <= B;
                            acc_hi <= '0;
                            cnt    <= CW'(WIDTH);
                            state  <= MUL;
                        end else begin
                            res      <= A;
                            res_hi   <= '0;
                            ovf      <= 1'b0;
                            err      <= 1'b0;
                            cnt      <= {1'b0, shamt};
                            shift_op <= op;
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    res <= shift_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        zero  <= (shift_next == '0);
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    mplier <= {mul_sum[0], mplier[WIDTH-1:1]};
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        res    <= {mul_sum[0], mplier[WIDTH-1:1]};
                        res_hi <= mul_sum[WIDTH:1];
                        zero   <= ({mul_sum[0], mplier[WIDTH-1:1]} == '0);
                        ovf    <= 1'b0;
                        err    <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a behavioural model pushes expected results at
// issue time, and each scenario pops and checks them when done appears.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  ALUop = '0;
    logic [5:0]  Fun = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] res, res_hi;
    logic        zero, ovf, err, busy, done;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        logic        err;
        int          cyc;
        int          bsy;
    } exp_t;

    exp_t sb[$];

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUop(ALUop), .Fun(Fun),
        .A(A), .B(B), .res(res), .res_hi(res_hi), .zero(zero), .ovf(ovf),
        .err(err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // cyc counts negedges from issue to the done sample: 1 for single-cycle ops, latency+1 otherwise.
    function automatic exp_t model(logic [1:0] op, logic [5:0] fn, logic [31:0] a, logic [31:0] b);
        exp_t   e;
        longint s;
        logic [63:0] p;
        int     n;
        e = '{res: '0, hi: '0, zero: 1'b0, ovf: 1'b0, err: 1'b0, cyc: 1, bsy: 0};
        n = int'(b[4:0]);
        if (op == 2'b00 || (op == 2'b10 && fn == 6'h20)) begin
            s = longint'($signed(a)) + longint'($signed(b));
            e.res = a + b;
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 2'b01 || (op == 2'b10 && fn == 6'h22)) begin
            s = longint'($signed(a)) - longint'($signed(b));
            e.res = a - b;
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 2'b11 || fn == 6'h25) begin
            e.res = a | b;
        end else begin
            case (fn)
                6'h24: e.res = a & b;
                6'h26: e.res = a ^ b;
                6'h27: e.res = ~(a | b);
                6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h00: e.res = a << n;
                6'h02: e.res = a >> n;
                6'h03: e.res = $signed(a) >>> n;
                6'h19: begin
                    p = 64'(a) * 64'(b);
                    e.res = p[31:0];
                    e.hi  = p[63:32];
                    e.cyc = 33;
                    e.bsy = 32;
                end
                default: e.err = 1'b1;
            endcase
            if ((fn == 6'h00 || fn == 6'h02 || fn == 6'h03) && n != 0) begin
                e.cyc = n + 1;
                e.bsy = n;
            end
        end
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Called at a negedge; drives one start pulse and returns at the following negedge.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        ALUop = op;
        Fun   = fn;
        A     = a;
        B     = b;
        sb.push_back(model(op, fn, a, b));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bc);
        cyc = 1;
        bc  = busy ? 1 : 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (busy) bc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({res, res_hi, zero, ovf, err, busy, done} !== 69'd0) begin
            miscompares++;
            $display("[TB] FAIL reset: res=%h hi=%h z%b o%b e%b busy%b done%b, expected all zero",
                     res, res_hi, zero, ovf, err, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        exp_t e;
        int   cyc, bc;
        issue(2'b00, 6'h00, 32'h7FFF_FFFF, 32'd1);
        wait_done(cyc, bc);
        e = sb.pop_front();
        vectors++;
        if (!done || cyc != e.cyc || busy !== 1'b0 || res !== 32'h8000_0000 || ovf !== 1'b1 ||
            {res, res_hi, zero, ovf, err} !== {e.res, e.hi, e.zero, e.ovf, e.err}) begin
            miscompares++;
            $display("[TB] FAIL add_ovf: res=%h ovf=%b zero=%b busy=%b cyc=%0d, expected res=%h ovf=%b zero=%b busy=0 cyc=%0d",
                     res, ovf, zero, busy, cyc, e.res, e.ovf, e.zero, e.cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_rtype();
        logic [5:0]  fns [4] = '{6'h22, 6'h2A, 6'h3F, 6'h27};
        logic [31:0] as  [4] = '{32'd5, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0F0F_0000};
        logic [31:0] bs  [4] = '{32'd5, 32'd1, 32'h9ABC_DEF0, 32'h00F0_F0F0};
        exp_t e;
        int   cyc, bc;
        for (int i = 0; i < 4; i++) begin
            issue(2'b10, fns[i], as[i], bs[i]);
            wait_done(cyc, bc);
            e = sb.pop_front();
            vectors++;
            if (!done || cyc != e.cyc || {res, res_hi, zero, ovf, err} !== {e.res, e.hi, e.zero, e.ovf, e.err}) begin
                miscompares++;
                $display("[TB] FAIL rtype fun=%h: res=%h z%b o%b e%b cyc=%0d, expected res=%h z%b o%b e%b cyc=%0d",
                         fns[i], res, zero, ovf, err, cyc, e.res, e.zero, e.ovf, e.err, e.cyc);
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || res !== e.res) begin
            miscompares++;
            $display("[TB] FAIL hold: done=%b res=%h, expected done=0 res=%h", done, res, e.res);
        end
    endtask

    task automatic test_shift();
        logic [5:0]  fns [5] = '{6'h03, 6'h00, 6'h02, 6'h00, 6'h03};
        logic [31:0] as  [5] = '{32'h8000_0000, 32'hDEAD_BEEF, 32'hF000_0001, 32'h0000_0001, 32'h4000_0000};
        logic [31:0] bs  [5] = '{32'd4, 32'd0, 32'd7, 32'd31, 32'hFFFF_FFE2};
        exp_t e;
        int   cyc, bc;
        for (int i = 0; i < 5; i++) begin
            issue(2'b10, fns[i], as[i], bs[i]);
            wait_done(cyc, bc);
            e = sb.pop_front();
            vectors++;
            if (!done || cyc != e.cyc || bc != e.bsy ||
                {res, res_hi, zero, ovf, err} !== {e.res, e.hi, e.zero, e.ovf, e.err}) begin
                miscompares++;
                $display("[TB] FAIL shift fun=%h b=%h: res=%h z%b cyc=%0d busy=%0d, expected res=%h z%b cyc=%0d busy=%0d",
                         fns[i], bs[i], res, zero, cyc, bc, e.res, e.zero, e.cyc, e.bsy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mult();
        exp_t e;
        int   cyc, bc, extra;
        issue(2'b10, 6'h19, 32'hFFFF_FFFF, 32'd2);
        cyc = 1;
        bc  = busy ? 1 : 0;
        while (!done && cyc < 60) begin
            if (cyc == 10) begin
                ALUop = 2'b00;
                A     = 32'd5;
                B     = 32'd7;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) bc++;
        end
        e = sb.pop_front();
        vectors++;
        if (!done || cyc != e.cyc || bc != e.bsy || res !== 32'hFFFF_FFFE || res_hi !== 32'd1 ||
            {res, res_hi, zero, ovf, err} !== {e.res, e.hi, e.zero, e.ovf, e.err}) begin
            miscompares++;
            $display("[TB] FAIL multu: res=%h hi=%h cyc=%0d busy=%0d, expected res=%h hi=%h cyc=%0d busy=%0d",
                     res, res_hi, cyc, bc, e.res, e.hi, e.cyc, e.bsy);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("[TB] FAIL ignored_start: extra done pulses=%0d, expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc, bc;
        issue(2'b10, 6'h19, 32'h0001_2345, 32'h0006_789A);
        wait_done(cyc, bc);
        e = sb.pop_front();
        vectors++;
        if (!done || cyc != e.cyc || {res, res_hi, zero} !== {e.res, e.hi, e.zero}) begin
            miscompares++;
            $display("[TB] FAIL b2b_mult: res=%h hi=%h cyc=%0d, expected res=%h hi=%h cyc=%0d",
                     res, res_hi, cyc, e.res, e.hi, e.cyc);
        end
        issue(2'b00, 6'h00, 32'd3, 32'd4);
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || res !== 32'd7 || res_hi !== 32'd0 || {res, res_hi, zero, ovf, err} !== {e.res, e.hi, e.zero, e.ovf, e.err}) begin
            miscompares++;
            $display("[TB] FAIL b2b_add: done=%b res=%h hi=%h, expected done=1 res=%h hi=%h", done, res, res_hi, e.res, e.hi);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_width: done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_reset_midop();
        int dones;
        issue(2'b10, 6'h19, 32'hCAFE_F00D, 32'h1357_9BDF);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        vectors++;
        if (busy !== 1'b0 || res !== 32'd0 || res_hi !== 32'd0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_reset: busy=%b res=%h hi=%h done=%b, expected all 0", busy, res, res_hi, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("[TB] FAIL post_abort: done/busy seen %0d cycles, expected 0", dones);
        end
    endtask

    task automatic test_random();
        logic [5:0] fns [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h00, 6'h02, 6'h03, 6'h19, 6'h01};
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a, b;
        exp_t e;
        int   cyc, bc;
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = fns[$urandom_range(0, 11)];
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 0) b = a;
            issue(op, fn, a, b);
            wait_done(cyc, bc);
            e = sb.pop_front();
            vectors++;
            if (!done || cyc != e.cyc || bc != e.bsy ||
                {res, res_hi, zero, ovf, err} !== {e.res, e.hi, e.zero, e.ovf, e.err}) begin
                miscompares++;
                $display("[TB] FAIL random op=%b fun=%h a=%h b=%h: res=%h hi=%h z%b o%b e%b cyc=%0d, expected res=%h hi=%h z%b o%b e%b cyc=%0d",
                         op, fn, a, b, res, res_hi, zero, ovf, err, cyc, e.res, e.hi, e.zero, e.ovf, e.err, e.cyc);
            end
            if (i % 3 == 0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_rtype();
        test_shift();
        test_mult();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
